// File: rtl/sram_req_arbiter.sv
// Shares one sram-like port between the inst and data requesters, with in-order response steering.
// Define SRAM_ARB_RR_EN for round-robin arbitration. Without it, data has fixed priority over inst.
module sram_req_arbiter #(
   parameter int MAX_OUT = 4,
   parameter int CNT_W   = 4
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic              inst_req,
   input  logic              inst_wr,
   input  logic [1:0]        inst_size,
   input  logic [31:0]       inst_addr,
   input  logic [3:0]        inst_wstrb,
   input  logic [31:0]       inst_wdata,
   output logic              inst_addr_ok,
   output logic              inst_data_ok,
   output logic [31:0]       inst_rdata,
   input  logic              data_req,
   input  logic              data_wr,
   input  logic [1:0]        data_size,
   input  logic [31:0]       data_addr,
   input  logic [3:0]        data_wstrb,
   input  logic [31:0]       data_wdata,
   output logic              data_addr_ok,
   output logic              data_data_ok,
   output logic [31:0]       data_rdata,
   output logic              sram_req,
   output logic              sram_wr,
   output logic [1:0]        sram_size,
   output logic [31:0]       sram_addr,
   output logic [3:0]        sram_wstrb,
   output logic [31:0]       sram_wdata,
   input  logic              sram_addr_ok,
   input  logic              sram_data_ok,
   input  logic [31:0]       sram_rdata,
   output logic [CNT_W-1:0]  inst_io_cnt,
   output logic [CNT_W-1:0]  data_io_cnt
);
   localparam int PW = (MAX_OUT > 2) ? $clog2(MAX_OUT) : 1;

   typedef enum logic {ARB_IDLE, ARB_LOCK} arb_st_t;

   arb_st_t          r_state, w_state_nxt;
   logic             r_lock;
   logic             r_fifo [MAX_OUT];
   logic [PW-1:0]    r_rd_ptr, r_wr_ptr;
   logic [CNT_W-1:0] r_inst_cnt, r_data_cnt;
   logic [CNT_W:0]   w_total;
   logic             w_full, w_empty, w_pick, w_sel, w_sram_req, w_hs, w_pop, w_head;

   assign w_total = {1'b0, r_inst_cnt} + {1'b0, r_data_cnt};
   assign w_full  = (w_total == (CNT_W+1)'(MAX_OUT));
   assign w_empty = (w_total == '0);

`ifdef SRAM_ARB_RR_EN
   logic r_last;
   // On a tie, the requester that did not win last time goes first.
   assign w_pick = (inst_req && data_req) ? ~r_last : data_req;
   always_ff @(posedge clk or negedge resetn)
      if (!resetn)   r_last <= 1'b0;
      else if (w_hs) r_last <= w_sel;
`else
   assign w_pick = data_req;
`endif

   always_comb begin
      w_state_nxt = r_state;
      w_sel       = w_pick;
      w_sram_req  = 1'b0;
      case (r_state)
         ARB_IDLE: begin
            if (!w_full && (inst_req || data_req)) begin
               w_sram_req = 1'b1;
               if (!sram_addr_ok) w_state_nxt = ARB_LOCK;
            end
         end
         ARB_LOCK: begin
            // The held request owns the port until it is accepted, even if it drops req.
            w_sel      = r_lock;
            w_sram_req = r_lock ? data_req : inst_req;
            if (w_sram_req && sram_addr_ok) w_state_nxt = ARB_IDLE;
         end
         default: w_state_nxt = ARB_IDLE;
      endcase
   end

   assign w_hs   = w_sram_req && sram_addr_ok;
   assign w_pop  = sram_data_ok && !w_empty;
   assign w_head = r_fifo[r_rd_ptr];

   assign sram_req   = w_sram_req;
   assign sram_wr    = w_sel ? data_wr    : inst_wr;
   assign sram_size  = w_sel ? data_size  : inst_size;
   assign sram_addr  = w_sel ? data_addr  : inst_addr;
   assign sram_wstrb = w_sel ? data_wstrb : inst_wstrb;
   assign sram_wdata = w_sel ? data_wdata : inst_wdata;

   assign inst_addr_ok = w_hs && !w_sel;
   assign data_addr_ok = w_hs &&  w_sel;
   assign inst_data_ok = w_pop && !w_head;
   assign data_data_ok = w_pop &&  w_head;
   assign inst_rdata   = sram_rdata;
   assign data_rdata   = sram_rdata;
   assign inst_io_cnt  = r_inst_cnt;
   assign data_io_cnt  = r_data_cnt;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_state    <= ARB_IDLE;
         r_lock     <= 1'b0;
         r_rd_ptr   <= '0;
         r_wr_ptr   <= '0;
         r_inst_cnt <= '0;
         r_data_cnt <= '0;
         for (int i = 0; i < MAX_OUT; i++) r_fifo[i] <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         if (r_state == ARB_IDLE && w_sram_req && !sram_addr_ok) r_lock <= w_sel;
         if (w_hs) begin
            r_fifo[r_wr_ptr] <= w_sel;
            r_wr_ptr         <= r_wr_ptr + 1'b1;
         end
         if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
         r_inst_cnt <= r_inst_cnt + CNT_W'(inst_addr_ok) - CNT_W'(inst_data_ok);
         r_data_cnt <= r_data_cnt + CNT_W'(data_addr_ok) - CNT_W'(data_data_ok);
      end
   end
endmodule

// File: tb/tb_sram_req_arbiter.sv
// Randomized bench for sram_req_arbiter against a queue-based transaction model.
module tb_sram_req_arbiter;
   localparam int MAX_OUT = 4;
   localparam int CNT_W   = 4;

   logic        clk = 1'b0, resetn = 1'b0;
   logic        inst_req = 0, inst_wr = 0, data_req = 0, data_wr = 0;
   logic [1:0]  inst_size = 0, data_size = 0;
   logic [31:0] inst_addr = 0, inst_wdata = 0, data_addr = 0, data_wdata = 0;
   logic [3:0]  inst_wstrb = 0, data_wstrb = 0;
   logic        inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
   logic [31:0] inst_rdata, data_rdata;
   logic        sram_req, sram_wr;
   logic [1:0]  sram_size;
   logic [31:0] sram_addr, sram_wdata;
   logic [3:0]  sram_wstrb;
   logic        sram_addr_ok = 0, sram_data_ok = 0;
   logic [31:0] sram_rdata = 0;
   logic [CNT_W-1:0] inst_io_cnt, data_io_cnt;

   sram_req_arbiter #(.MAX_OUT(MAX_OUT), .CNT_W(CNT_W)) dut (
      .clk(clk), .resetn(resetn),
      .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size), .inst_addr(inst_addr),
      .inst_wstrb(inst_wstrb), .inst_wdata(inst_wdata), .inst_addr_ok(inst_addr_ok),
      .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
      .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_addr(data_addr),
      .data_wstrb(data_wstrb), .data_wdata(data_wdata), .data_addr_ok(data_addr_ok),
      .data_data_ok(data_data_ok), .data_rdata(data_rdata),
      .sram_req(sram_req), .sram_wr(sram_wr), .sram_size(sram_size), .sram_addr(sram_addr),
      .sram_wstrb(sram_wstrb), .sram_wdata(sram_wdata), .sram_addr_ok(sram_addr_ok),
      .sram_data_ok(sram_data_ok), .sram_rdata(sram_rdata),
      .inst_io_cnt(inst_io_cnt), .data_io_cnt(data_io_cnt)
   );

   always #5 clk = ~clk;

   int n_vec = 0, n_err = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Model: in-order queue of accepted requester IDs (0=inst, 1=data) and the current port owner.
   int q[$];
   int owner = -1;
   int last  = 0;
   bit ipend = 0, dpend = 0;
   int full_hits = 0;

   function automatic int n_of(int id);
      int n = 0;
      foreach (q[i]) if (q[i] == id) n++;
      return n;
   endfunction

   task automatic model_reset();
      q.delete();
      owner = -1; last = 0; ipend = 0; dpend = 0;
   endtask

   task automatic cycle(int p_req, int p_aok, int p_dok);
      bit ereq, hs, pop;
      int w, head;
      @(posedge clk); #1;
      if (!ipend && $urandom_range(99) < p_req) begin
         ipend = 1; inst_wr = 1'($urandom); inst_size = 2'($urandom_range(2));
         inst_addr = $urandom; inst_wstrb = 4'($urandom); inst_wdata = $urandom;
      end
      if (!dpend && $urandom_range(99) < p_req) begin
         dpend = 1; data_wr = 1'($urandom); data_size = 2'($urandom_range(2));
         data_addr = $urandom; data_wstrb = 4'($urandom); data_wdata = $urandom;
      end
      inst_req     = ipend;
      data_req     = dpend;
      sram_addr_ok = ($urandom_range(99) < p_aok);
      sram_data_ok = ($urandom_range(99) < p_dok);
      sram_rdata   = $urandom;
      #3;
      w = 0; ereq = 0;
      if (owner < 0) begin
         if (q.size() < MAX_OUT && (ipend || dpend)) begin
            ereq = 1;
`ifdef SRAM_ARB_RR_EN
            w = (ipend && dpend) ? 1 - last : (dpend ? 1 : 0);
`else
            w = dpend ? 1 : 0;
`endif
         end else if (q.size() == MAX_OUT && (ipend || dpend)) full_hits++;
      end else begin
         w = owner;
         ereq = (w == 1) ? dpend : ipend;
      end
      hs   = ereq && sram_addr_ok;
      pop  = sram_data_ok && q.size() > 0;
      head = (q.size() > 0) ? q[0] : 0;

      chk("sram_req", 32'(sram_req), 32'(ereq));
      if (ereq) begin
         chk("sram_addr",  sram_addr,  w ? data_addr  : inst_addr);
         chk("sram_wdata", sram_wdata, w ? data_wdata : inst_wdata);
         chk("sram_ctl", 32'({sram_wr, sram_size, sram_wstrb}),
             w ? 32'({data_wr, data_size, data_wstrb}) : 32'({inst_wr, inst_size, inst_wstrb}));
      end
      chk("inst_addr_ok", 32'(inst_addr_ok), 32'(hs && w == 0));
      chk("data_addr_ok", 32'(data_addr_ok), 32'(hs && w == 1));
      chk("inst_data_ok", 32'(inst_data_ok), 32'(pop && head == 0));
      chk("data_data_ok", 32'(data_data_ok), 32'(pop && head == 1));
      if (pop) begin
         chk("inst_rdata", inst_rdata, sram_rdata);
         chk("data_rdata", data_rdata, sram_rdata);
      end
      chk("inst_io_cnt", 32'(inst_io_cnt), 32'(n_of(0)));
      chk("data_io_cnt", 32'(data_io_cnt), 32'(n_of(1)));

      if (pop) void'(q.pop_front());
      if (hs) begin
         q.push_back(w); owner = -1; last = w;
         if (w == 0) ipend = 0; else dpend = 0;
      end else if (ereq && owner < 0) owner = w;
   endtask

   initial begin
      #2;
      chk("rst_sram_req", 32'(sram_req), 0);
      chk("rst_aok", 32'({inst_addr_ok, data_addr_ok}), 0);
      chk("rst_cnt", 32'({inst_io_cnt, data_io_cnt}), 0);
      #10 resetn = 1'b1;

      for (int i = 0; i < 600; i++) cycle(50, 60, 35);  // mixed traffic
      for (int i = 0; i < 400; i++) cycle(80, 70, 8);   // saturate to full
      for (int i = 0; i < 300; i++) cycle(40, 30, 80);  // drain, stray data_ok
      for (int i = 0; i < 300; i++) cycle(90, 95, 50);  // back-to-back contention

      // Reset with transactions outstanding.
      for (int i = 0; i < 30; i++) cycle(90, 90, 0);
      @(negedge clk);
      inst_req = 0; data_req = 0; sram_data_ok = 0; sram_addr_ok = 0;
      resetn = 1'b0;
      #1;
      chk("arst_cnt", 32'({inst_io_cnt, data_io_cnt}), 0);
      chk("arst_sram_req", 32'(sram_req), 0);
      model_reset();
      @(negedge clk) resetn = 1'b1;
      for (int i = 0; i < 20; i++) cycle(0, 50, 100);   // stray responses must be ignored
      for (int i = 0; i < 300; i++) cycle(60, 50, 40);

      chk("full_seen", 32'(full_hits > 0), 1);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
